ts_release_sched: RTL and testbench

Release scheduler for the timestamp FIFO. It watches the head entry presented by the FIFO (future timestamp plus valid) and compares its release-time field against the free-running local time. When an entry falls due, it issues exactly one pop and a one-cycle release strobe carrying that entry. It also supports a software flush that drains the FIFO without releasing, and it exposes release and late counters to the register block.

---
 rtl/ts_release_sched_if.sv | 32 +++
 rtl/ts_release_sched.sv | 175 +++++++++++++++++
 tb/tb_ts_release_sched.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ts_release_sched_if.sv
// Handshake bundle between the timestamp FIFO / register block and the
// release scheduler. The slave modport is the scheduler's view.
interface ts_release_sched_if #(
  parameter int TS_W   = 108,
  parameter int TIME_W = 64
);
  logic [TS_W-1:0]   iFUTURE_TS;
  logic              iFTS_VALID;
  logic [TIME_W-1:0] iCUR_TIME;
  logic              iENABLE;
  logic              iFLUSH;
  logic              oTS_FIFO_POP;
  logic              oRELEASE;
  logic [TS_W-1:0]   oRELEASE_TS;
  logic              oFLUSH_DONE;
  logic [31:0]       oREG_REL_CNT;
  logic [15:0]       oREG_LATE_CNT;
  logic [15:0]       oREG_FLUSH_CNT;
  logic [1:0]        oREG_STATE;

  modport slave (
    input  iFUTURE_TS, iFTS_VALID, iCUR_TIME, iENABLE, iFLUSH,
    output oTS_FIFO_POP, oRELEASE, oRELEASE_TS, oFLUSH_DONE,
           oREG_REL_CNT, oREG_LATE_CNT, oREG_FLUSH_CNT, oREG_STATE
  );

  modport master (
    output iFUTURE_TS, iFTS_VALID, iCUR_TIME, iENABLE, iFLUSH,
    input  oTS_FIFO_POP, oRELEASE, oRELEASE_TS, oFLUSH_DONE,
           oREG_REL_CNT, oREG_LATE_CNT, oREG_FLUSH_CNT, oREG_STATE
  );
endinterface

// File: rtl/ts_release_sched.sv
// Release scheduler for the timestamp FIFO: pops the head entry once its
// release time is reached (wrap-safe signed compare against local time),
// strobes it out, supports a drain-only flush, and keeps release/late/flush
// counters for the register block. One pop per 1+GUARD+1 cycles at most.
module ts_release_sched #(
  parameter int                TS_W        = 108,
  parameter int                TIME_W      = 64,
  parameter int                GUARD       = 3,
  parameter logic [TIME_W-1:0] LATE_THRESH = 64'd1000
) (
  input logic               clk,
  input logic               rst,
  ts_release_sched_if.slave bus
);

  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POP   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_flush_pend;
  logic              r_is_flush;
  logic              r_late;
  logic [GW-1:0]     r_guard_cnt;
  logic              r_pop;
  logic              r_release;
  logic              r_flush_done;
  logic [TS_W-1:0]   r_release_ts;
  logic [31:0]       r_rel_cnt;
  logic [15:0]       r_late_cnt;
  logic [15:0]       r_flush_cnt;

  logic signed [TIME_W-1:0] w_delta;
  logic              w_due;
  logic              w_late;
  logic              w_capture;
  logic              w_pop_is_flush;
  logic              w_flush_clr;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Wrap-safe due/late decision: difference taken modulo 2^TIME_W, sign bit
  // tells whether the release time has been reached.
  assign w_delta = $signed(bus.iCUR_TIME - bus.iFUTURE_TS[TIME_W-1:0]);
  assign w_due   = ~w_delta[TIME_W-1];
  assign w_late  = w_due && (w_delta > $signed(LATE_THRESH));

  // Next-state and transition decode; a pending flush outranks a release.
  always_comb begin
    w_next         = r_state;
    w_capture      = 1'b0;
    w_pop_is_flush = 1'b0;
    w_flush_clr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_flush_pend) begin
          if (bus.iFTS_VALID) begin
            w_next         = POP;
            w_pop_is_flush = 1'b1;
          end else begin
            w_flush_clr = 1'b1;
          end
        end else if (bus.iENABLE) begin
          w_next = ARMED;
        end
      end
      ARMED: begin
        if (r_flush_pend) begin
          if (bus.iFTS_VALID) begin
            w_next         = POP;
            w_pop_is_flush = 1'b1;
          end else begin
            w_flush_clr = 1'b1;
          end
        end else if (!bus.iENABLE) begin
          w_next = IDLE;
        end else if (bus.iFTS_VALID && w_due) begin
          w_next    = POP;
          w_capture = 1'b1;
        end
      end
      POP:  w_next = HOLD;
      HOLD: begin
        if (r_guard_cnt == '0) begin
          w_next = bus.iENABLE ? ARMED : IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register, flush request latch and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_flush_pend <= 1'b0;
      r_is_flush   <= 1'b0;
      r_pop        <= 1'b0;
      r_release    <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_state <= w_next;
      if (bus.iFLUSH) begin
        r_flush_pend <= 1'b1;
      end else if (w_flush_clr) begin
        r_flush_pend <= 1'b0;
      end
      if (w_next == POP) begin
        r_is_flush <= w_pop_is_flush;
      end
      r_pop        <= (w_next == POP);
      r_release    <= w_capture;
      r_flush_done <= w_flush_clr;
    end
  end

  // Guard counter: loaded while popping, counts down through HOLD so the
  // FIFO's read-to-head-valid latency is never mistaken for a new entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_guard_cnt <= '0;
    end else if (r_state == POP) begin
      r_guard_cnt <= GW'(GUARD - 1);
    end else if (r_state == HOLD && r_guard_cnt != '0) begin
      r_guard_cnt <= r_guard_cnt - 1'b1;
    end
  end

  // Capture of the released entry and its lateness at the release decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_release_ts <= '0;
      r_late       <= 1'b0;
    end else if (w_capture) begin
      r_release_ts <= bus.iFUTURE_TS;
      r_late       <= w_late;
    end
  end

  // Statistics counters, updated at the edge that ends POP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rel_cnt   <= '0;
      r_late_cnt  <= '0;
      r_flush_cnt <= '0;
    end else if (r_state == POP) begin
      if (!r_is_flush) begin
        r_rel_cnt <= r_rel_cnt + 32'd1;
        if (r_late) begin
          r_late_cnt <= sat_inc16(r_late_cnt);
        end
      end else begin
        r_flush_cnt <= sat_inc16(r_flush_cnt);
      end
    end
  end

  assign bus.oTS_FIFO_POP   = r_pop;
  assign bus.oRELEASE       = r_release;
  assign bus.oRELEASE_TS    = r_release_ts;
  assign bus.oFLUSH_DONE    = r_flush_done;
  assign bus.oREG_REL_CNT   = r_rel_cnt;
  assign bus.oREG_LATE_CNT  = r_late_cnt;
  assign bus.oREG_FLUSH_CNT = r_flush_cnt;
  assign bus.oREG_STATE     = r_state;

endmodule

// File: tb/tb_ts_release_sched.sv
// Bench for ts_release_sched: a small FIFO model feeds the head entry with a
// two-cycle read latency; released entries are scoreboarded against the
// entries expected to be released.
module tb_ts_release_sched;

  typedef logic [107:0] ts_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ts_release_sched_if #(.TS_W(108), .TIME_W(64)) bus ();

  ts_release_sched #(
    .TS_W(108), .TIME_W(64), .GUARD(3), .LATE_THRESH(64'd1000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc = 0, pop_cnt = 0, rel_cnt = 0, done_cnt = 0, done_cyc = -1;
  int arm_cyc = -1, watch_cyc = -1, busy = 0, underflow = 0;
  bit watch_en = 1'b0;
  logic [63:0] tnow = 64'd0, tinc = 64'd1, watch_time = 64'd0;
  ts_t fifo_q[$];
  ts_t exp_q[$];
  ts_t rel_obs_q[$];
  int  pop_cyc_q[$];
  int  rel_cyc_q[$];

  // One clock: observe registered outputs, advance the FIFO model, drive inputs.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.oREG_STATE == 2'd1 && arm_cyc < 0) arm_cyc = cyc;
    if (bus.oTS_FIFO_POP) begin
      pop_cnt++;
      pop_cyc_q.push_back(cyc);
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      else underflow++;
      busy = 2;
    end else if (busy > 0) begin
      busy--;
    end
    if (bus.oRELEASE) begin
      rel_cnt++;
      rel_obs_q.push_back(bus.oRELEASE_TS);
      rel_cyc_q.push_back(cyc);
    end
    if (bus.oFLUSH_DONE) begin
      done_cnt++;
      done_cyc = cyc;
    end
    bus.iCUR_TIME = tnow;
    if (watch_en && tnow == watch_time && watch_cyc < 0) watch_cyc = cyc;
    tnow = tnow + tinc;
    if (busy == 0 && fifo_q.size() > 0) begin
      bus.iFTS_VALID = 1'b1;
      bus.iFUTURE_TS = fifo_q[0];
    end else begin
      bus.iFTS_VALID = 1'b0;
      bus.iFUTURE_TS = '0;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    bus.iENABLE = 1'b0;
    bus.iFLUSH  = 1'b0;
    fifo_q.delete();
    busy = 0;
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    exp_q.delete(); rel_obs_q.delete(); pop_cyc_q.delete(); rel_cyc_q.delete();
    pop_cnt = 0; rel_cnt = 0; done_cnt = 0; done_cyc = -1;
    arm_cyc = -1; watch_cyc = -1; watch_en = 1'b0; underflow = 0;
  endtask

  // Bounded wait for the n-th pop since the last reset.
  task automatic run_pops(input int n, input int budget);
    int k;
    k = 0;
    while (pop_cnt < n && k < budget) begin
      step();
      k++;
    end
    total++;
    if (pop_cnt < n) begin
      bad++;
      $display("FAIL pop_timeout: pops=%0d required=%0d", pop_cnt, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    steps(2);
    total += 8;
    if (bus.oTS_FIFO_POP !== 1'b0) begin bad++; $display("FAIL rst_pop: got %b want 0", bus.oTS_FIFO_POP); end
    if (bus.oRELEASE !== 1'b0) begin bad++; $display("FAIL rst_release: got %b want 0", bus.oRELEASE); end
    if (bus.oRELEASE_TS !== '0) begin bad++; $display("FAIL rst_ts: got %h want 0", bus.oRELEASE_TS); end
    if (bus.oFLUSH_DONE !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", bus.oFLUSH_DONE); end
    if (bus.oREG_REL_CNT !== 32'd0) begin bad++; $display("FAIL rst_relcnt: got %0d want 0", bus.oREG_REL_CNT); end
    if (bus.oREG_LATE_CNT !== 16'd0) begin bad++; $display("FAIL rst_latecnt: got %0d want 0", bus.oREG_LATE_CNT); end
    if (bus.oREG_FLUSH_CNT !== 16'd0) begin bad++; $display("FAIL rst_flushcnt: got %0d want 0", bus.oREG_FLUSH_CNT); end
    if (bus.oREG_STATE !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", bus.oREG_STATE); end
  endtask

  task automatic test_on_time();
    ts_t e;
    do_reset();
    e = {44'h0_0ABC_0000_0001, 64'd100};
    fifo_q.push_back(e); exp_q.push_back(e);
    tnow = 64'd90; tinc = 64'd1; watch_time = 64'd100; watch_en = 1'b1;
    bus.iENABLE = 1'b1;
    run_pops(1, 40);
    steps(8);
    total += 6;
    if (pop_cnt != 1) begin bad++; $display("FAIL ontime_pops: got %0d want 1", pop_cnt); end
    if (pop_cyc_q.size() == 0 || pop_cyc_q[0] != watch_cyc + 1) begin
      bad++; $display("FAIL ontime_latency: pop cycle %0d want %0d", (pop_cyc_q.size() > 0) ? pop_cyc_q[0] : -1, watch_cyc + 1);
    end
    if (rel_cyc_q.size() == 0 || rel_cyc_q[0] != watch_cyc + 1) begin
      bad++; $display("FAIL ontime_strobe: release cycle %0d want %0d", (rel_cyc_q.size() > 0) ? rel_cyc_q[0] : -1, watch_cyc + 1);
    end
    if (bus.oREG_REL_CNT !== 32'd1) begin bad++; $display("FAIL ontime_relcnt: got %0d want 1", bus.oREG_REL_CNT); end
    if (bus.oREG_LATE_CNT !== 16'd0) begin bad++; $display("FAIL ontime_latecnt: got %0d want 0", bus.oREG_LATE_CNT); end
    if (bus.oRELEASE_TS !== e) begin bad++; $display("FAIL ontime_hold_ts: got %h want %h", bus.oRELEASE_TS, e); end
    while (exp_q.size() > 0) begin
      ts_t x;
      x = exp_q.pop_front();
      total++;
      if (rel_obs_q.size() == 0) begin bad++; $display("FAIL ontime_sb: got none want %h", x); end
      else begin
        ts_t o;
        o = rel_obs_q.pop_front();
        if (o !== x) begin bad++; $display("FAIL ontime_sb: got %h want %h", o, x); end
      end
    end
  endtask

  task automatic test_late();
    ts_t e;
    ts_t o;
    do_reset();
    e = {44'h0_0000_0000_0777, 64'd100};
    fifo_q.push_back(e); exp_q.push_back(e);
    tnow = 64'd2000; tinc = 64'd1;
    bus.iENABLE = 1'b1;
    run_pops(1, 20);
    steps(6);
    total += 5;
    if (pop_cyc_q.size() == 0 || pop_cyc_q[0] != arm_cyc + 1) begin
      bad++; $display("FAIL late_latency: pop cycle %0d want %0d", (pop_cyc_q.size() > 0) ? pop_cyc_q[0] : -1, arm_cyc + 1);
    end
    if (bus.oREG_LATE_CNT !== 16'd1) begin bad++; $display("FAIL late_latecnt: got %0d want 1", bus.oREG_LATE_CNT); end
    if (bus.oREG_REL_CNT !== 32'd1) begin bad++; $display("FAIL late_relcnt: got %0d want 1", bus.oREG_REL_CNT); end
    if (rel_obs_q.size() != 1) begin bad++; $display("FAIL late_relnum: got %0d want 1", rel_obs_q.size()); end
    else begin
      o = rel_obs_q.pop_front();
      if (o !== exp_q.pop_front()) begin bad++; $display("FAIL late_sb: got %h want %h", o, e); end
    end
    if (pop_cnt != 1) begin bad++; $display("FAIL late_pops: got %0d want 1", pop_cnt); end
  endtask

  task automatic test_wrap();
    ts_t e;
    ts_t o;
    do_reset();
    e = {44'h0_0000_0000_0055, 64'h0000_0000_0000_0005};
    fifo_q.push_back(e); exp_q.push_back(e);
    tnow = 64'hFFFF_FFFF_FFFF_FFF0; tinc = 64'd1;
    watch_time = 64'h0000_0000_0000_0005; watch_en = 1'b1;
    bus.iENABLE = 1'b1;
    run_pops(1, 40);
    steps(10);
    total += 4;
    if (pop_cnt != 1) begin bad++; $display("FAIL wrap_pops: got %0d want 1", pop_cnt); end
    if (pop_cyc_q.size() == 0 || pop_cyc_q[0] != watch_cyc + 1) begin
      bad++; $display("FAIL wrap_latency: pop cycle %0d want %0d", (pop_cyc_q.size() > 0) ? pop_cyc_q[0] : -1, watch_cyc + 1);
    end
    if (bus.oREG_REL_CNT !== 32'd1) begin bad++; $display("FAIL wrap_relcnt: got %0d want 1", bus.oREG_REL_CNT); end
    if (rel_obs_q.size() != 1) begin bad++; $display("FAIL wrap_relnum: got %0d want 1", rel_obs_q.size()); end
    else begin
      o = rel_obs_q.pop_front();
      total++;
      if (o !== exp_q.pop_front()) begin bad++; $display("FAIL wrap_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ts_t e;
      e = {44'(32'hB2B0 + i), 64'(10 * (i + 1))};
      fifo_q.push_back(e); exp_q.push_back(e);
    end
    tnow = 64'd500; tinc = 64'd1;
    bus.iENABLE = 1'b1;
    run_pops(3, 40);
    steps(12);
    total += 5;
    if (pop_cnt != 3) begin bad++; $display("FAIL b2b_pops: got %0d want 3", pop_cnt); end
    if (pop_cyc_q.size() < 3 || pop_cyc_q[1] - pop_cyc_q[0] != 5) begin
      bad++; $display("FAIL b2b_gap1: got %0d want 5", (pop_cyc_q.size() > 1) ? pop_cyc_q[1] - pop_cyc_q[0] : -1);
    end
    if (pop_cyc_q.size() < 3 || pop_cyc_q[2] - pop_cyc_q[1] != 5) begin
      bad++; $display("FAIL b2b_gap2: got %0d want 5", (pop_cyc_q.size() > 2) ? pop_cyc_q[2] - pop_cyc_q[1] : -1);
    end
    if (bus.oREG_REL_CNT !== 32'd3) begin bad++; $display("FAIL b2b_relcnt: got %0d want 3", bus.oREG_REL_CNT); end
    if (bus.oREG_LATE_CNT !== 16'd0) begin bad++; $display("FAIL b2b_latecnt: got %0d want 0", bus.oREG_LATE_CNT); end
    while (exp_q.size() > 0) begin
      ts_t x;
      x = exp_q.pop_front();
      total++;
      if (rel_obs_q.size() == 0) begin bad++; $display("FAIL b2b_sb: got none want %h", x); end
      else begin
        ts_t o;
        o = rel_obs_q.pop_front();
        if (o !== x) begin bad++; $display("FAIL b2b_sb: got %h want %h", o, x); end
      end
    end
  endtask

  task automatic test_flush();
    int k;
    do_reset();
    for (int i = 0; i < 4; i++) fifo_q.push_back({44'(32'hF100 + i), 64'(1000000 + i)});
    tnow = 64'd0; tinc = 64'd1;
    bus.iENABLE = 1'b1;
    steps(5);
    total++;
    if (pop_cnt != 0) begin bad++; $display("FAIL flush_early_pop: got %0d want 0", pop_cnt); end
    bus.iFLUSH = 1'b1;
    step();
    bus.iFLUSH = 1'b0;
    run_pops(4, 60);
    k = 0;
    while (done_cnt == 0 && k < 20) begin step(); k++; end
    steps(6);
    total += 7;
    if (pop_cnt != 4) begin bad++; $display("FAIL flush_pops: got %0d want 4", pop_cnt); end
    if (rel_cnt != 0) begin bad++; $display("FAIL flush_releases: got %0d want 0", rel_cnt); end
    if (bus.oREG_FLUSH_CNT !== 16'd4) begin bad++; $display("FAIL flush_cnt: got %0d want 4", bus.oREG_FLUSH_CNT); end
    if (bus.oREG_REL_CNT !== 32'd0) begin bad++; $display("FAIL flush_relcnt: got %0d want 0", bus.oREG_REL_CNT); end
    if (done_cnt != 1) begin bad++; $display("FAIL flush_done_cnt: got %0d want 1", done_cnt); end
    if (pop_cyc_q.size() == 0 || done_cyc <= pop_cyc_q[pop_cyc_q.size() - 1]) begin
      bad++; $display("FAIL flush_done_order: done cycle %0d must follow last pop", done_cyc);
    end
    if (bus.oRELEASE_TS !== '0) begin bad++; $display("FAIL flush_ts_held: got %h want 0", bus.oRELEASE_TS); end
  endtask

  task automatic test_flush_coincident();
    ts_t e1;
    ts_t o;
    int  dec_cyc;
    int  k;
    do_reset();
    e1 = {44'h0_0000_0000_0C01, 64'd10};
    fifo_q.push_back(e1); exp_q.push_back(e1);
    fifo_q.push_back({44'h0_0000_0000_0C02, 64'd1000000});
    tnow = 64'd500; tinc = 64'd1;
    bus.iENABLE = 1'b1;
    step();
    bus.iFLUSH = 1'b1;
    step();
    dec_cyc = cyc;
    bus.iFLUSH = 1'b0;
    run_pops(2, 30);
    k = 0;
    while (done_cnt == 0 && k < 20) begin step(); k++; end
    steps(4);
    total += 6;
    if (pop_cyc_q.size() == 0 || pop_cyc_q[0] != dec_cyc) begin
      bad++; $display("FAIL coinc_first_pop: cycle %0d want %0d", (pop_cyc_q.size() > 0) ? pop_cyc_q[0] : -1, dec_cyc);
    end
    if (pop_cnt != 2) begin bad++; $display("FAIL coinc_pops: got %0d want 2", pop_cnt); end
    if (bus.oREG_REL_CNT !== 32'd1) begin bad++; $display("FAIL coinc_relcnt: got %0d want 1", bus.oREG_REL_CNT); end
    if (bus.oREG_FLUSH_CNT !== 16'd1) begin bad++; $display("FAIL coinc_flushcnt: got %0d want 1", bus.oREG_FLUSH_CNT); end
    if (done_cnt != 1) begin bad++; $display("FAIL coinc_done: got %0d want 1", done_cnt); end
    if (rel_obs_q.size() != 1) begin bad++; $display("FAIL coinc_relnum: got %0d want 1", rel_obs_q.size()); end
    else begin
      o = rel_obs_q.pop_front();
      total++;
      if (o !== exp_q.pop_front()) begin bad++; $display("FAIL coinc_sb: got %h want %h", o, e1); end
    end
  endtask

  task automatic test_disable_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      ts_t e;
      e = {44'(32'hD100 + i), 64'(10 + i)};
      fifo_q.push_back(e); exp_q.push_back(e);
    end
    tnow = 64'd500; tinc = 64'd1;
    bus.iENABLE = 1'b1;
    run_pops(1, 20);
    bus.iENABLE = 1'b0;
    steps(15);
    total += 3;
    if (pop_cnt != 1) begin bad++; $display("FAIL dis_pops: got %0d want 1", pop_cnt); end
    if (bus.oREG_STATE !== 2'd0) begin bad++; $display("FAIL dis_state: got %0d want 0", bus.oREG_STATE); end
    if (bus.oREG_REL_CNT !== 32'd1) begin bad++; $display("FAIL dis_relcnt: got %0d want 1", bus.oREG_REL_CNT); end
    bus.iENABLE = 1'b1;
    run_pops(2, 20);
    step();
    total++;
    if (bus.oREG_STATE !== 2'd3) begin bad++; $display("FAIL rsthold_state_pre: got %0d want 3", bus.oREG_STATE); end
    while (exp_q.size() > 0) begin
      ts_t x;
      x = exp_q.pop_front();
      total++;
      if (rel_obs_q.size() == 0) begin bad++; $display("FAIL dis_sb: got none want %h", x); end
      else begin
        ts_t o;
        o = rel_obs_q.pop_front();
        if (o !== x) begin bad++; $display("FAIL dis_sb: got %h want %h", o, x); end
      end
    end
    rst = 1'b1;
    step();
    total += 7;
    if (bus.oREG_STATE !== 2'd0) begin bad++; $display("FAIL rsthold_state: got %0d want 0", bus.oREG_STATE); end
    if (bus.oTS_FIFO_POP !== 1'b0) begin bad++; $display("FAIL rsthold_pop: got %b want 0", bus.oTS_FIFO_POP); end
    if (bus.oRELEASE !== 1'b0) begin bad++; $display("FAIL rsthold_release: got %b want 0", bus.oRELEASE); end
    if (bus.oRELEASE_TS !== '0) begin bad++; $display("FAIL rsthold_ts: got %h want 0", bus.oRELEASE_TS); end
    if (bus.oREG_REL_CNT !== 32'd0) begin bad++; $display("FAIL rsthold_relcnt: got %0d want 0", bus.oREG_REL_CNT); end
    if (bus.oREG_LATE_CNT !== 16'd0) begin bad++; $display("FAIL rsthold_latecnt: got %0d want 0", bus.oREG_LATE_CNT); end
    if (bus.oREG_FLUSH_CNT !== 16'd0) begin bad++; $display("FAIL rsthold_flushcnt: got %0d want 0", bus.oREG_FLUSH_CNT); end
    rst = 1'b0;
    bus.iENABLE = 1'b0;
    steps(8);
    total += 2;
    if (pop_cnt != 2) begin bad++; $display("FAIL rsthold_pops: got %0d want 2", pop_cnt); end
    if (underflow != 0) begin bad++; $display("FAIL underflow: got %0d want 0", underflow); end
  endtask

  initial begin
    bus.iFUTURE_TS = '0;
    bus.iFTS_VALID = 1'b0;
    bus.iCUR_TIME  = '0;
    bus.iENABLE    = 1'b0;
    bus.iFLUSH     = 1'b0;
    test_reset();
    test_on_time();
    test_late();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_flush_coincident();
    test_disable_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
